// File: rtl/obi_wrr_arbiter_pkg.sv
// rtl/obi_wrr_arbiter_pkg.sv - shared types, constants and helpers for the OBI weighted round-robin arbiter
package obi_wrr_arbiter_pkg;

  typedef enum logic {
    ARB,
    HOLD
  } arb_state_e;

  localparam int unsigned StatsCntWidth = 16;

  // A programmed weight of zero still earns one grant per turn.
  function automatic logic [31:0] eff_weight(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/obi_wrr_arbiter_if.sv
// rtl/obi_wrr_arbiter_if.sv - OBI A/R channel bundle for N ports sharing one broadcast R payload
interface obi_wrr_arbiter_if #(
  parameter int unsigned N         = 1,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 5
);
  logic [N-1:0]               req;
  logic [N-1:0]               gnt;
  logic [N*AddrWidth-1:0]     addr;
  logic [N-1:0]               we;
  logic [N*(DataWidth/8)-1:0] be;
  logic [N*DataWidth-1:0]     wdata;
  logic [N*IdWidth-1:0]       aid;
  logic [N-1:0]               rvalid;
  logic [DataWidth-1:0]       rdata;
  logic                       err;
  logic [IdWidth-1:0]         rid;

  modport master (
    output req, addr, we, be, wdata, aid,
    input  gnt, rvalid, rdata, err, rid
  );

  modport slave (
    input  req, addr, we, be, wdata, aid,
    output gnt, rvalid, rdata, err, rid
  );
endinterface

// File: rtl/obi_wrr_idx_fifo.sv
// rtl/obi_wrr_idx_fifo.sv - in-order FIFO of granted requester indices used to route responses
module obi_wrr_idx_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  // A pop from empty is dropped; a push at full is accepted only alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem[rd_ptr];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/obi_wrr_arbiter.sv
// rtl/obi_wrr_arbiter.sv - weighted round-robin OBI arbiter, NumReq managers onto one subordinate port
// Optional grant statistics: define OBI_WRR_ARBITER_STATS_EN.
module obi_wrr_arbiter
  import obi_wrr_arbiter_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned IdWidth     = 5,
  parameter int unsigned NumMaxTrans = 8,
  parameter int unsigned WeightWidth = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReq*WeightWidth-1:0]     weight_i,
  obi_wrr_arbiter_if.slave                  sbr,
  obi_wrr_arbiter_if.master                 mgr,
  output logic [$clog2(NumMaxTrans+1)-1:0]  outstanding_o,
  input  logic                              stats_clr_i,
  output logic [NumReq*StatsCntWidth-1:0]   stats_gnt_cnt_o
);
  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned BeW  = DataWidth / 8;

  arb_state_e             state_q;
  logic [IdxW-1:0]        owner_q, sel_q, arb_sel, sel, head;
  logic [WeightWidth-1:0] credit_q;
  logic                   req, grant, pop, full, empty;
  int unsigned            idx;

  // Descending scan so the last hit is the first requester after owner_q; owner_q itself comes last.
  always_comb begin
    arb_sel = owner_q;
    idx     = 0;
    if (!(sbr.req[owner_q] && credit_q != '0)) begin
      for (int unsigned i = NumReq; i >= 1; i--) begin
        idx = (32'(owner_q) + i) % NumReq;
        if (sbr.req[idx]) arb_sel = IdxW'(idx);
      end
    end
  end

  assign sel   = (state_q == HOLD) ? sel_q : arb_sel;
  assign req   = ~rst_i & ((state_q == HOLD) ? sbr.req[sel_q] : (|sbr.req & ~full));
  assign grant = req & mgr.gnt[0];

  assign mgr.req   = req;
  assign mgr.addr  = sbr.addr[sel*AddrWidth +: AddrWidth];
  assign mgr.we    = sbr.we[sel];
  assign mgr.be    = sbr.be[sel*BeW +: BeW];
  assign mgr.wdata = sbr.wdata[sel*DataWidth +: DataWidth];
  assign mgr.aid   = sbr.aid[sel*IdWidth +: IdWidth];
  assign sbr.gnt   = grant ? (NumReq'(1) << sel) : '0;

  assign pop        = ~rst_i & mgr.rvalid[0] & ~empty;
  assign sbr.rvalid = pop ? (NumReq'(1) << head) : '0;
  assign sbr.rdata  = mgr.rdata;
  assign sbr.err    = mgr.err;
  assign sbr.rid    = mgr.rid;

  obi_wrr_idx_fifo #(
    .Depth (NumMaxTrans),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (grant),
    .wdata (sel),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (outstanding_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB;
      owner_q  <= IdxW'(NumReq - 1);
      credit_q <= '0;
      sel_q    <= '0;
    end else begin
      if (grant) begin
        if (sel == owner_q && credit_q != '0) begin
          credit_q <= credit_q - 1'b1;
        end else begin
          owner_q  <= sel;
          credit_q <= WeightWidth'(eff_weight(32'(weight_i[sel*WeightWidth +: WeightWidth])) - 32'd1);
        end
      end
      unique case (state_q)
        ARB: begin
          if (req && !mgr.gnt[0]) begin
            sel_q   <= arb_sel;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Leaving on a dropped request abandons the transfer without a push.
          if (grant || !sbr.req[sel_q]) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

`ifdef OBI_WRR_ARBITER_STATS_EN
  logic [NumReq-1:0][StatsCntWidth-1:0] stats_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i) begin
      stats_q <= '0;
    end else if (grant && stats_q[sel] != '1) begin
      stats_q[sel] <= stats_q[sel] + 1'b1;
    end
  end

  assign stats_gnt_cnt_o = stats_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign stats_gnt_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_obi_wrr_arbiter.sv
// tb/tb_obi_wrr_arbiter.sv - randomized and directed self-checking bench for obi_wrr_arbiter
module tb_obi_wrr_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int MT = 8;
  localparam int WW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*WW-1:0]  weight;
  logic              stats_clr;
  logic [3:0]        outstanding;
  logic [NR*16-1:0]  stats;

  always #5 clk = ~clk;

  obi_wrr_arbiter_if #(.N(NR), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) sbr_bus ();
  obi_wrr_arbiter_if #(.N(1),  .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) mgr_bus ();

  obi_wrr_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .NumMaxTrans(MT), .WeightWidth(WW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .weight_i        (weight),
    .sbr             (sbr_bus),
    .mgr             (mgr_bus),
    .outstanding_o   (outstanding),
    .stats_clr_i     (stats_clr),
    .stats_gnt_cnt_o (stats)
  );

  // Reference: who holds the turn, how many extra grants remain in it, a pending
  // un-granted offer, and the queue of granted-but-unanswered requesters.
  int owner, turn_left, held;
  bit holding;
  int pending[$];
  int gcount[NR];

  int n_vec, n_fail;
  logic [NR-1:0] obs_gnt, obs_rv;
  logic          obs_req;
  logic [31:0]   obs_addr, obs_rdata;
  logic [3:0]    obs_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    owner     = NR - 1;
    turn_left = 0;
    holding   = 0;
    held      = 0;
    pending.delete();
    for (int k = 0; k < NR; k++) gcount[k] = 0;
  endfunction

  function automatic int pick(input logic [NR-1:0] r);
    if (r[owner] && turn_left > 0) return owner;
    for (int i = 1; i <= NR; i++)
      if (r[(owner + i) % NR]) return (owner + i) % NR;
    return owner;
  endfunction

  task automatic step();
    logic [NR-1:0] r, egv, erv;
    logic [63:0]   est;
    int            cand, w;
    bit            ereq, eg;
    @(negedge clk);
    r    = sbr_bus.req;
    cand = holding ? held : pick(r);
    if (rst)          ereq = 1'b0;
    else if (holding) ereq = r[held];
    else              ereq = (r != '0) && (pending.size() < MT);
    eg  = ereq && mgr_bus.gnt[0];
    egv = eg ? (NR'(1) << cand) : '0;
    erv = (!rst && mgr_bus.rvalid[0] && pending.size() > 0) ? (NR'(1) << pending[0]) : '0;
    est = '0;
`ifdef OBI_WRR_ARBITER_STATS_EN
    for (int k = 0; k < NR; k++) est[k*16 +: 16] = 16'(gcount[k]);
`endif
    chk("mgr_req", 64'(mgr_bus.req), 64'(ereq));
    chk("sbr_gnt", 64'(sbr_bus.gnt), 64'(egv));
    chk("sbr_rvalid", 64'(sbr_bus.rvalid), 64'(erv));
    chk("outstanding", 64'(outstanding), 64'(pending.size()));
    chk("r_payload", {27'd0, sbr_bus.rid, sbr_bus.err, sbr_bus.rdata},
        {27'd0, mgr_bus.rid, mgr_bus.err, mgr_bus.rdata});
    chk("stats", stats, est);
    if (ereq) begin
      chk("mgr_addr", 64'(mgr_bus.addr), 64'(sbr_bus.addr[cand*AW +: AW]));
      chk("mgr_ctl", {22'd0, mgr_bus.we, mgr_bus.be, mgr_bus.aid},
          {22'd0, sbr_bus.we[cand], sbr_bus.be[cand*4 +: 4], sbr_bus.aid[cand*IW +: IW]});
      chk("mgr_wdata", 64'(mgr_bus.wdata), 64'(sbr_bus.wdata[cand*DW +: DW]));
    end
    obs_gnt   = sbr_bus.gnt;
    obs_rv    = sbr_bus.rvalid;
    obs_req   = mgr_bus.req[0];
    obs_addr  = mgr_bus.addr;
    obs_rdata = sbr_bus.rdata;
    obs_out   = outstanding;
    if (rst) begin
      model_reset();
    end else begin
      if (erv != '0) void'(pending.pop_front());
      if (eg) begin
        pending.push_back(cand);
        if (cand == owner && turn_left > 0) begin
          turn_left--;
        end else begin
          owner     = cand;
          w         = int'(weight[cand*WW +: WW]);
          turn_left = ((w == 0) ? 1 : w) - 1;
        end
      end
      if (holding) begin
        if (eg || !r[held]) holding = 0;
      end else if (ereq && !eg) begin
        holding = 1;
        held    = cand;
      end
      if (stats_clr) begin
        for (int k = 0; k < NR; k++) gcount[k] = 0;
      end else if (eg && gcount[cand] < 65535) begin
        gcount[cand]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    sbr_bus.req    = '0;
    sbr_bus.addr   = '0;
    sbr_bus.we     = '0;
    sbr_bus.be     = '0;
    sbr_bus.wdata  = '0;
    sbr_bus.aid    = '0;
    mgr_bus.gnt    = '0;
    mgr_bus.rvalid = '0;
    mgr_bus.rdata  = '0;
    mgr_bus.err    = 1'b0;
    mgr_bus.rid    = '0;
    stats_clr      = 1'b0;
    weight         = 16'h1111;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int grants;
    n_vec = 0;
    n_fail = 0;
    model_reset();
    set_idle();
    rst = 1'b1;
    sbr_bus.req = '1;
    @(posedge clk);
    #1;
    repeat (3) step();
    chk("reset_req", 64'(obs_req), 64'd0);
    chk("reset_gnt", 64'(obs_gnt), 64'd0);
    chk("reset_outstanding", 64'(obs_out), 64'd0);
    rst = 1'b0;

    // Equal weights: strict rotation starting after the reset owner (NR-1).
    do_reset();
    sbr_bus.req = '1;
    mgr_bus.gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rotation", 64'(obs_gnt), 64'(4'b0001 << (i % 4)));
      mgr_bus.rvalid = 1'b1;
    end

    // w0=3 with w1 of 1 and then 0.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      weight = (p == 0) ? 16'h0013 : 16'h0003;
      sbr_bus.req = 4'b0011;
      mgr_bus.gnt = 1'b1;
      for (int i = 0; i < 8; i++) begin
        step();
        chk("weighted", 64'(obs_gnt), (i % 4 == 3) ? 64'h2 : 64'h1);
        mgr_bus.rvalid = 1'b1;
      end
    end

    // Stalled offer stays on requester 0 while requester 1 joins.
    do_reset();
    sbr_bus.addr = {32'h0, 32'h0, 32'h2200, 32'h1100};
    sbr_bus.req  = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) sbr_bus.req = 4'b0011;
      if (c == 6) mgr_bus.gnt = 1'b1;
      step();
      chk("hold_addr", 64'(obs_addr), 64'h1100);
      chk("hold_gnt", 64'(obs_gnt), (c == 6) ? 64'h1 : 64'h0);
    end

    // Outstanding cap.
    do_reset();
    sbr_bus.req = 4'b0001;
    mgr_bus.gnt = 1'b1;
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (obs_gnt != '0) grants++;
    end
    chk("cap_grants", 64'(grants), 64'd8);
    chk("cap_req", 64'(obs_req), 64'd0);
    chk("cap_outstanding", 64'(obs_out), 64'd8);
    mgr_bus.rvalid = 1'b1;
    step();
    chk("cap_rvalid", 64'(obs_rv), 64'h1);
    chk("cap_no_gnt", 64'(obs_gnt), 64'h0);
    mgr_bus.rvalid = 1'b0;
    step();
    chk("cap_ninth", 64'(obs_gnt), 64'h1);

    // Response routing and a stray response.
    do_reset();
    mgr_bus.gnt = 1'b1;
    sbr_bus.req = 4'b0100; step(); chk("route_g2", 64'(obs_gnt), 64'h4);
    sbr_bus.req = 4'b0001; step(); chk("route_g0", 64'(obs_gnt), 64'h1);
    sbr_bus.req = 4'b1000; step(); chk("route_g3", 64'(obs_gnt), 64'h8);
    sbr_bus.req = '0;
    mgr_bus.gnt = 1'b0;
    mgr_bus.rvalid = 1'b1;
    mgr_bus.rdata = 32'hA; step();
    chk("route_rv_a", 64'(obs_rv), 64'h4);
    chk("route_rd_a", 64'(obs_rdata), 64'hA);
    mgr_bus.rdata = 32'hB; step();
    chk("route_rv_b", 64'(obs_rv), 64'h1);
    chk("route_rd_b", 64'(obs_rdata), 64'hB);
    mgr_bus.rdata = 32'hC; step();
    chk("route_rv_c", 64'(obs_rv), 64'h8);
    chk("route_rd_c", 64'(obs_rdata), 64'hC);
    step();
    chk("stray_rv", 64'(obs_rv), 64'h0);
    chk("stray_outstanding", 64'(obs_out), 64'h0);
    mgr_bus.rvalid = 1'b0;

    // Randomized traffic against the reference.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      stats_clr      = ($urandom_range(0, 49) == 0);
      weight         = 16'($urandom);
      sbr_bus.req    = 4'($urandom);
      sbr_bus.addr   = {$urandom, $urandom, $urandom, $urandom};
      sbr_bus.we     = 4'($urandom);
      sbr_bus.be     = 16'($urandom);
      sbr_bus.wdata  = {$urandom, $urandom, $urandom, $urandom};
      sbr_bus.aid    = 20'($urandom);
      mgr_bus.gnt    = 1'($urandom_range(0, 3) != 0);
      mgr_bus.rvalid = 1'($urandom_range(0, 2) == 0);
      mgr_bus.rdata  = $urandom;
      mgr_bus.err    = 1'($urandom);
      mgr_bus.rid    = 5'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/obi_wrr_arbiter.md
Name: obi_wrr_arbiter

Overview:
Weighted round-robin scheduler that shares one OBI subordinate port between NumReq OBI managers. It sits in front of an OBI crossbar manager port or a single memory. Request path is a zero-latency mux. An in-order index FIFO routes each response back to the requester that was granted. Outstanding transactions are capped at NumMaxTrans.

Parameters:
NumReq, 4, number of requesting manager ports (>=2)
AddrWidth, 32, OBI address width
DataWidth, 32, OBI data width (be width = DataWidth/8)
IdWidth, 5, OBI aid/rid width (passed through unchanged)
NumMaxTrans, 8, maximum outstanding granted-but-unanswered transactions
WeightWidth, 4, width of each per-requester weight

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
weight_i  in  NumReq*WeightWidth  grants per turn for each requester; 0 is treated as 1
sbr_req_i  in  NumReq  requester req
sbr_gnt_o  out  NumReq  requester gnt
sbr_addr_i / sbr_we_i / sbr_be_i / sbr_wdata_i / sbr_aid_i  in  NumReq*{AddrWidth,1,DataWidth/8,DataWidth,IdWidth}  requester A-channel
sbr_rvalid_o  out  NumReq  one-hot response valid
sbr_rdata_o / sbr_err_o / sbr_rid_o  out  DataWidth/1/IdWidth  broadcast R-channel
mgr_req_o / mgr_addr_o / mgr_we_o / mgr_be_o / mgr_wdata_o / mgr_aid_o  out  1/AddrWidth/1/DataWidth/8/DataWidth/IdWidth  shared A-channel
mgr_gnt_i  in  1  shared gnt
mgr_rvalid_i / mgr_rdata_i / mgr_err_i / mgr_rid_i  in  1/DataWidth/1/IdWidth  shared R-channel (no rready)
outstanding_o  out  $clog2(NumMaxTrans+1)  in-flight count
stats_clr_i  in  1  clear statistics
stats_gnt_cnt_o  out  NumReq*16  per-requester grant counters

Behaviour:
- Reset values: mgr_req_o=0, sbr_gnt_o=0, sbr_rvalid_o=0, outstanding_o=0, FIFO empty, state=ARB, owner_q=NumReq-1, credit_q=0.
- Selection in state ARB (combinational):
  - If sbr_req_i[owner_q] is set and credit_q>0, select owner_q.
  - Otherwise select the first requester with req set, scanning from owner_q+1 with wrap-around; owner_q is checked last.
- Full gating: full = (registered count == NumMaxTrans). In ARB, mgr_req_o = (|sbr_req_i) & ~full. A/wdata/aid fields are muxed from the selected requester.
- Grant path: sbr_gnt_o[k] = mgr_gnt_i & mgr_req_o & (sel==k). This path is combinational.
- Credit update on a grant to k:
  - If k==owner_q and credit_q>0: credit_q--.
  - Otherwise: owner_q<=k, credit_q<=max(weight_i[k],1)-1.
  - weight_i is sampled only at this reload.
- Index FIFO: each grant pushes k.
- ARB to HOLD: mgr_req_o=1 with mgr_gnt_i=0 → latch sel into sel_q and move to HOLD.
- HOLD:
  - Selection is frozen at sel_q. mgr_req_o = sbr_req_i[sel_q], and the full check is ignored (count cannot rise).
  - On gnt: push sel_q, apply the credit update, go to ARB.
  - If sbr_req_i[sel_q] drops (protocol violation): go to ARB with no push.
- Response path: mgr_rvalid_i pops the FIFO head h. sbr_rvalid_o = onehot(h). rdata/err/rid are broadcast. Latency is 0 cycles.
- Count update: push only → +1; pop only → -1; push and pop in the same cycle → unchanged. Full is taken from the registered count, so a pop frees a slot from the next cycle.
- mgr_rvalid_i with an empty FIFO is ignored: no sbr_rvalid_o, count stays 0.
- rst_i mid-transfer: all state returns to reset values on the next edge and in-flight responses are dropped.

Optional Feature:
- Macro: OBI_WRR_ARBITER_STATS_EN.
- Defined:
  - stats_gnt_cnt_o[k] is a 16-bit saturating counter, +1 on each grant to k.
  - stats_clr_i clears all counters the next cycle; clear wins over a simultaneous grant.
  - Counters reset to 0.
- Undefined: counters are not built, stats_gnt_cnt_o is tied to 0 and stats_clr_i is ignored.

Decomposition:
- Package obi_wrr_arbiter_pkg holds:
  - state enum arb_state_e {ARB, HOLD};
  - StatsCntWidth = 16;
  - function eff_weight(w) = (w==0)?1:w.
- Sub-module obi_wrr_idx_fifo: depth NumMaxTrans, width $clog2(NumReq), synchronous active-high reset, push/pop/full/empty/count outputs, simultaneous push+pop allowed at full and at empty+push.

Test Plan:
- Reset: rst_i high 3 cycles with sbr_req_i=4'b1111 → mgr_req_o=0, sbr_gnt_o=0, outstanding_o=0.
- Fair rotation: weights {1,1,1,1}, all req high, mgr_gnt_i=1, rvalid 1 cycle later → grant sequence 0,1,2,3,0,1…
- Weighting: w0=3, w1=1 (weight 0 on w1 gives the same result), req0/req1 held → grant order 0,0,0,1,0,0,0,1.
- HOLD stability: req0 addr 0x1100, mgr_gnt_i=0 for 5 cycles; req1 rises at cycle 2 → mgr_addr_o stays 0x1100 and 0 is granted at cycle 6.
- Cap: NumMaxTrans=8, no rvalid → exactly 8 grants, then mgr_req_o=0 and outstanding_o=8. One rvalid → 9th grant the following cycle.
- Routing: grants to 2,0,3, then 3 rvalids with rdata 0xA,0xB,0xC → sbr_rvalid_o 4'b0100, 4'b0001, 4'b1000 carrying 0xA, 0xB, 0xC. A stray rvalid when empty → no output.
